instr_decode_ctrl: RTL and testbench

Instruction decode and sequencing controller that sits directly upstream of the 8x8-bit register file. It accepts one 32-bit instruction per handshake and decodes it into the register-file controls (OUT1ADDRESS, OUT2ADDRESS, INADDRESS, WRITE) plus the ALU, immediate and memory controls. A multi-cycle FSM sequences each instruction through decode, execute, memory wait and writeback. WRITE is guaranteed to be high for exactly one rising CLK edge per register-writing instruction.

---
 rtl/instr_decode_ctrl_if.sv | 36 +++
 rtl/instr_decode_ctrl.sv | 134 +++++++++++++
 tb/tb_instr_decode_ctrl.sv | 242 ++++++++++++++++++++++++
 3 files changed

// File: rtl/instr_decode_ctrl_if.sv
// Instruction handshake plus the register-file, ALU and memory control bundle
// driven by instr_decode_ctrl.
interface instr_decode_ctrl_if #(
  parameter int RAW = 3,
  parameter int DW  = 8
);
  logic           INSTR_VALID;
  logic [31:0]    INSTR;
  logic           INSTR_READY;
  logic           ZERO;
  logic           MEM_BUSY;
  logic [RAW-1:0] OUT1ADDRESS;
  logic [RAW-1:0] OUT2ADDRESS;
  logic [RAW-1:0] INADDRESS;
  logic           WRITE;
  logic [DW-1:0]  IMMEDIATE;
  logic           IMM_SEL;
  logic           NEG_SEL;
  logic [2:0]     ALUOP;
  logic           MEM_READ;
  logic           MEM_WRITE;
  logic           BRANCH_TAKEN;
  logic           ILLEGAL;

  modport master (
    output INSTR_VALID, INSTR, ZERO, MEM_BUSY,
    input  INSTR_READY, OUT1ADDRESS, OUT2ADDRESS, INADDRESS, WRITE, IMMEDIATE,
           IMM_SEL, NEG_SEL, ALUOP, MEM_READ, MEM_WRITE, BRANCH_TAKEN, ILLEGAL
  );

  modport slave (
    input  INSTR_VALID, INSTR, ZERO, MEM_BUSY,
    output INSTR_READY, OUT1ADDRESS, OUT2ADDRESS, INADDRESS, WRITE, IMMEDIATE,
           IMM_SEL, NEG_SEL, ALUOP, MEM_READ, MEM_WRITE, BRANCH_TAKEN, ILLEGAL
  );
endinterface

// File: rtl/instr_decode_ctrl.sv
// Multi-cycle instruction decode/sequencing controller feeding the 8x8 register
// file: IDLE -> DECODE -> EXECUTE -> (MEM_WAIT) -> (WRITEBACK) -> IDLE.
module instr_decode_ctrl #(
  parameter int OPW = 8,
  parameter int RAW = 3,
  parameter int DW  = 8
) (
  input  logic               CLK,
  input  logic               RESET,
  instr_decode_ctrl_if.slave bus,
  output logic [2:0]         dbg_state
);
  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_DECODE    = 3'd1,
    S_EXECUTE   = 3'd2,
    S_MEM_WAIT  = 3'd3,
    S_WRITEBACK = 3'd4
  } state_t;

  localparam logic [OPW-1:0] OP_LOADI = OPW'(8'h00), OP_MOV  = OPW'(8'h01);
  localparam logic [OPW-1:0] OP_ADD   = OPW'(8'h02), OP_SUB  = OPW'(8'h03);
  localparam logic [OPW-1:0] OP_AND   = OPW'(8'h04), OP_OR   = OPW'(8'h05);
  localparam logic [OPW-1:0] OP_J     = OPW'(8'h06), OP_BEQ  = OPW'(8'h07);
  localparam logic [OPW-1:0] OP_LWD   = OPW'(8'h08), OP_LWI  = OPW'(8'h09);
  localparam logic [OPW-1:0] OP_SWD   = OPW'(8'h0A), OP_SWI  = OPW'(8'h0B);
  localparam logic [OPW-1:0] OP_MULT  = OPW'(8'h0C), OP_SLL  = OPW'(8'h0D);
  localparam logic [OPW-1:0] OP_SRL   = OPW'(8'h0E), OP_BNE  = OPW'(8'h0F);

  localparam logic [2:0] ALU_FWD = 3'b000, ALU_ADD  = 3'b001, ALU_AND   = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011, ALU_MULT = 3'b100, ALU_SHIFT = 3'b101;

  state_t         state, state_nxt;
  logic [31:0]    ir;
  logic           run_q;
  logic           accept;
  logic [OPW-1:0] opc;
  logic           is_load, is_store, is_jump, is_beq, is_bne, is_illegal;
  logic           unused_ir;

  // Handshake: INSTR is captured on a rising edge where INSTR_VALID && INSTR_READY.
  // READY is high only in IDLE (and not until one edge after reset release).
  assign accept     = bus.INSTR_READY && bus.INSTR_VALID;
  assign opc        = ir[31 -: OPW];
  assign is_load    = (opc == OP_LWD) || (opc == OP_LWI);
  assign is_store   = (opc == OP_SWD) || (opc == OP_SWI);
  assign is_jump    = (opc == OP_J);
  assign is_beq     = (opc == OP_BEQ);
  assign is_bne     = (opc == OP_BNE);
  assign is_illegal = (opc > OP_BNE);
  assign unused_ir  = ^ir[15:11];
  assign dbg_state  = state;

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state <= S_IDLE;
      ir    <= '0;
      run_q <= 1'b0;
    end else begin
      state <= state_nxt;
      run_q <= 1'b1;
      if (accept) ir <= bus.INSTR;
    end
  end

  // Decode fields are forced to zero in IDLE so reset leaves every output low.
  always_comb begin
    bus.OUT1ADDRESS = '0;
    bus.OUT2ADDRESS = '0;
    bus.INADDRESS   = '0;
    bus.IMMEDIATE   = '0;
    bus.IMM_SEL     = 1'b0;
    bus.NEG_SEL     = 1'b0;
    bus.ALUOP       = ALU_FWD;
    if (state != S_IDLE) begin
      bus.OUT1ADDRESS = ir[8 +: RAW];
      bus.OUT2ADDRESS = ir[0 +: RAW];
      bus.INADDRESS   = ir[16 +: RAW];
      bus.IMMEDIATE   = (is_jump || is_beq || is_bne) ? ir[16 +: DW] : ir[0 +: DW];
      case (opc)
        OP_LOADI, OP_LWI, OP_SWI: bus.IMM_SEL = 1'b1;
        OP_ADD:                   bus.ALUOP   = ALU_ADD;
        OP_SUB, OP_BEQ, OP_BNE: begin
          bus.ALUOP   = ALU_ADD;
          bus.NEG_SEL = 1'b1;
        end
        OP_AND:                   bus.ALUOP   = ALU_AND;
        OP_OR:                    bus.ALUOP   = ALU_OR;
        OP_MULT:                  bus.ALUOP   = ALU_MULT;
        OP_SLL, OP_SRL: begin
          bus.ALUOP   = ALU_SHIFT;
          bus.IMM_SEL = 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    state_nxt        = state;
    bus.INSTR_READY  = 1'b0;
    bus.WRITE        = 1'b0;
    bus.MEM_READ     = 1'b0;
    bus.MEM_WRITE    = 1'b0;
    bus.BRANCH_TAKEN = 1'b0;
    bus.ILLEGAL      = 1'b0;
    case (state)
      S_IDLE: begin
        bus.INSTR_READY = run_q;
        if (accept) state_nxt = S_DECODE;
      end
      S_DECODE: begin
        bus.ILLEGAL = is_illegal;
        state_nxt   = is_illegal ? S_IDLE : S_EXECUTE;
      end
      S_EXECUTE: begin
        bus.BRANCH_TAKEN = is_jump || (is_beq && bus.ZERO) || (is_bne && !bus.ZERO);
        if (is_load || is_store)                state_nxt = S_MEM_WAIT;
        else if (is_jump || is_beq || is_bne)   state_nxt = S_IDLE;
        else                                    state_nxt = S_WRITEBACK;
      end
      S_MEM_WAIT: begin
        bus.MEM_READ  = is_load;
        bus.MEM_WRITE = is_store;
        if (!bus.MEM_BUSY) state_nxt = is_load ? S_WRITEBACK : S_IDLE;
      end
      S_WRITEBACK: begin
        bus.WRITE = 1'b1;
        state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end
endmodule

// File: tb/tb_instr_decode_ctrl.sv
// Directed bench for instr_decode_ctrl: driver tasks push expected events,
// a negedge monitor pops and compares every event the controller produces.
module tb_instr_decode_ctrl;
  localparam int W = 32;
  localparam logic [3:0] EV_DEC = 4'd1, EV_WR = 4'd2, EV_BR = 4'd3;
  localparam logic [3:0] EV_ILL = 4'd4, EV_MRD = 4'd5, EV_MWR = 4'd6;

  logic       CLK;
  logic       RESET;
  logic [2:0] dbg_state;

  instr_decode_ctrl_if #(.RAW(3), .DW(8)) bus();

  instr_decode_ctrl dut (
    .CLK       (CLK),
    .RESET     (RESET),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  // ---------------- scoreboard ----------------
  logic [W-1:0] exp_q[$];
  int n_cmp = 0;
  int n_bad = 0;
  int mon_cyc = 0;
  int hs_cyc = -100;
  int mcnt = 0;
  logic mrd = 1'b0;

  function automatic logic [W-1:0] dec_ev(input logic [2:0] o1, input logic [2:0] o2,
                                          input logic [2:0] ia, input logic [2:0] op,
                                          input logic neg, input logic isel,
                                          input logic [7:0] imm);
    return {EV_DEC, 6'b0, o1, o2, ia, op, neg, isel, imm};
  endfunction

  function automatic logic [W-1:0] wr_ev(input logic [2:0] addr, input logic [7:0] lat);
    return {EV_WR, 17'b0, addr, lat};
  endfunction

  function automatic logic [W-1:0] br_ev(input logic [7:0] imm);
    return {EV_BR, 20'b0, imm};
  endfunction

  function automatic logic [W-1:0] ill_ev();
    return {EV_ILL, 28'b0};
  endfunction

  function automatic logic [W-1:0] mem_ev(input logic [3:0] kind, input logic [7:0] n);
    return {kind, 20'b0, n};
  endfunction

  function automatic logic [27:0] all_outs();
    return {bus.INSTR_READY, bus.OUT1ADDRESS, bus.OUT2ADDRESS, bus.INADDRESS, bus.WRITE,
            bus.IMMEDIATE, bus.IMM_SEL, bus.NEG_SEL, bus.ALUOP, bus.MEM_READ,
            bus.MEM_WRITE, bus.BRANCH_TAKEN, bus.ILLEGAL};
  endfunction

  task automatic chk(input string name, input logic [W-1:0] got, input logic [W-1:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%h expected=%h (t=%0t)", name, got, exp, $time);
    end
  endtask

  task automatic observe(input logic [W-1:0] got);
    if (exp_q.size() == 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL unexpected_event: got=%h expected=none (t=%0t)", got, $time);
    end else begin
      chk("event", got, exp_q.pop_front());
    end
  endtask

  // Monitor: one negedge per cycle; the cycle after a sampled handshake is DECODE.
  initial begin
    forever begin
      @(negedge CLK);
      mon_cyc++;
      if (mon_cyc == hs_cyc + 1)
        observe(dec_ev(bus.OUT1ADDRESS, bus.OUT2ADDRESS, bus.INADDRESS, bus.ALUOP,
                       bus.NEG_SEL, bus.IMM_SEL, bus.IMMEDIATE));
      if (bus.ILLEGAL) observe(ill_ev());
      if (bus.BRANCH_TAKEN) observe(br_ev(bus.IMMEDIATE));
      if (bus.MEM_READ || bus.MEM_WRITE) begin
        mcnt++;
        mrd = bus.MEM_READ;
      end else if (mcnt > 0) begin
        observe(mem_ev(mrd ? EV_MRD : EV_MWR, 8'(mcnt)));
        mcnt = 0;
      end
      if (bus.WRITE) observe(wr_ev(bus.INADDRESS, 8'(mon_cyc - hs_cyc)));
      if (bus.INSTR_VALID && bus.INSTR_READY) hs_cyc = mon_cyc;
    end
  end

  // ---------------- driver ----------------
  task automatic issue(input logic [31:0] instr, input logic z, input int nbusy);
    int t;
    t = 0;
    while (!bus.INSTR_READY && t < 50) begin
      @(posedge CLK); #1;
      t++;
    end
    if (!bus.INSTR_READY) begin
      n_cmp++;
      n_bad++;
      $display("FAIL ready_timeout: got=0 expected=1 (t=%0t)", $time);
    end
    bus.INSTR       = instr;
    bus.ZERO        = z;
    bus.MEM_BUSY    = (nbusy > 0);
    bus.INSTR_VALID = 1'b1;
    @(posedge CLK); #1;
    bus.INSTR_VALID = 1'b0;
    if (nbusy > 0) begin
      t = 0;
      while (!(bus.MEM_READ || bus.MEM_WRITE) && t < 10) begin
        @(posedge CLK); #1;
        t++;
      end
      if (!(bus.MEM_READ || bus.MEM_WRITE)) begin
        n_cmp++;
        n_bad++;
        $display("FAIL mem_req_timeout: got=0 expected=1 (t=%0t)", $time);
      end
      repeat (nbusy) @(posedge CLK);
      #1 bus.MEM_BUSY = 1'b0;
    end
  endtask

  // ---------------- directed stimulus ----------------
  initial begin
    RESET           = 1'b0;
    bus.INSTR_VALID = 1'b0;
    bus.INSTR       = '0;
    bus.ZERO        = 1'b0;
    bus.MEM_BUSY    = 1'b0;
    #3;
    chk("reset_outputs", {4'b0, all_outs()}, 32'h0);
    chk("reset_state", {29'b0, dbg_state}, 32'h0);
    #9 RESET = 1'b1;
    @(posedge CLK); #1;
    chk("ready_after_init", {31'b0, bus.INSTR_READY}, 32'h1);

    // ADD r4 = r2 + r1
    exp_q.push_back(dec_ev(3'd2, 3'd1, 3'd4, 3'b001, 1'b0, 1'b0, 8'h01));
    exp_q.push_back(wr_ev(3'd4, 8'd3));
    issue(32'h02040201, 1'b0, 0);
    chk("ready_low_in_decode", {31'b0, bus.INSTR_READY}, 32'h0);
    repeat (3) @(posedge CLK);
    #1 chk("ready_back_after_add", {31'b0, bus.INSTR_READY}, 32'h1);

    // LOADI r3 = 0x2A
    exp_q.push_back(dec_ev(3'd0, 3'd2, 3'd3, 3'b000, 1'b0, 1'b1, 8'h2A));
    exp_q.push_back(wr_ev(3'd3, 8'd3));
    issue(32'h0003002A, 1'b0, 0);
    // SUB r5 = r1 - r2
    exp_q.push_back(dec_ev(3'd1, 3'd2, 3'd5, 3'b001, 1'b1, 1'b0, 8'h02));
    exp_q.push_back(wr_ev(3'd5, 8'd3));
    issue(32'h03050102, 1'b0, 0);
    // LWD r6, busy for 3 MEM_WAIT cycles -> 4 request cycles, write at edge 7
    exp_q.push_back(dec_ev(3'd3, 3'd0, 3'd6, 3'b000, 1'b0, 1'b0, 8'h00));
    exp_q.push_back(mem_ev(EV_MRD, 8'd4));
    exp_q.push_back(wr_ev(3'd6, 8'd7));
    issue(32'h08060300, 1'b0, 3);
    // LWI r3, no busy -> 1 request cycle, write at edge 4
    exp_q.push_back(dec_ev(3'd0, 3'd5, 3'd3, 3'b000, 1'b0, 1'b1, 8'h05));
    exp_q.push_back(mem_ev(EV_MRD, 8'd1));
    exp_q.push_back(wr_ev(3'd3, 8'd4));
    issue(32'h09030005, 1'b0, 0);
    // SWI, busy 1 cycle -> 2 request cycles, no write
    exp_q.push_back(dec_ev(3'd1, 3'd7, 3'd0, 3'b000, 1'b0, 1'b1, 8'h07));
    exp_q.push_back(mem_ev(EV_MWR, 8'd2));
    issue(32'h0B000107, 1'b0, 1);
    // BEQ taken / not taken
    exp_q.push_back(dec_ev(3'd1, 3'd2, 3'd6, 3'b001, 1'b1, 1'b0, 8'hFE));
    exp_q.push_back(br_ev(8'hFE));
    issue(32'h07FE0102, 1'b1, 0);
    exp_q.push_back(dec_ev(3'd1, 3'd2, 3'd6, 3'b001, 1'b1, 1'b0, 8'hFE));
    issue(32'h07FE0102, 1'b0, 0);
    // BNE taken / not taken
    exp_q.push_back(dec_ev(3'd1, 3'd2, 3'd6, 3'b001, 1'b1, 1'b0, 8'hFE));
    exp_q.push_back(br_ev(8'hFE));
    issue(32'h0FFE0102, 1'b0, 0);
    exp_q.push_back(dec_ev(3'd1, 3'd2, 3'd6, 3'b001, 1'b1, 1'b0, 8'hFE));
    issue(32'h0FFE0102, 1'b1, 0);
    // Illegal opcode 0x3C, then MOV accepted normally
    exp_q.push_back(dec_ev(3'd4, 3'd6, 3'd2, 3'b000, 1'b0, 1'b0, 8'h56));
    exp_q.push_back(ill_ev());
    issue(32'h3C123456, 1'b0, 0);
    exp_q.push_back(dec_ev(3'd5, 3'd0, 3'd7, 3'b000, 1'b0, 1'b0, 8'h00));
    exp_q.push_back(wr_ev(3'd7, 8'd3));
    issue(32'h01070500, 1'b0, 0);
    // J, MULT, SLL, AND, OR
    exp_q.push_back(dec_ev(3'd0, 3'd0, 3'd0, 3'b000, 1'b0, 1'b0, 8'h80));
    exp_q.push_back(br_ev(8'h80));
    issue(32'h06800000, 1'b0, 0);
    exp_q.push_back(dec_ev(3'd2, 3'd3, 3'd1, 3'b100, 1'b0, 1'b0, 8'h03));
    exp_q.push_back(wr_ev(3'd1, 8'd3));
    issue(32'h0C010203, 1'b0, 0);
    exp_q.push_back(dec_ev(3'd1, 3'd4, 3'd2, 3'b101, 1'b0, 1'b1, 8'h04));
    exp_q.push_back(wr_ev(3'd2, 8'd3));
    issue(32'h0D020104, 1'b0, 0);
    exp_q.push_back(dec_ev(3'd6, 3'd5, 3'd0, 3'b010, 1'b0, 1'b0, 8'h05));
    exp_q.push_back(wr_ev(3'd0, 8'd3));
    issue(32'h04000605, 1'b0, 0);
    exp_q.push_back(dec_ev(3'd7, 3'd3, 3'd1, 3'b011, 1'b0, 1'b0, 8'h03));
    exp_q.push_back(wr_ev(3'd1, 8'd3));
    issue(32'h05010703, 1'b0, 0);

    // Reset during ADD in EXECUTE: abort, all outputs low, no write
    exp_q.push_back(dec_ev(3'd2, 3'd1, 3'd4, 3'b001, 1'b0, 1'b0, 8'h01));
    issue(32'h02040201, 1'b0, 0);
    @(posedge CLK); #1;
    RESET = 1'b0;
    #1 chk("mid_reset_outputs", {4'b0, all_outs()}, 32'h0);
    @(posedge CLK); #3;
    RESET = 1'b1;
    #1 chk("ready_low_at_release", {31'b0, bus.INSTR_READY}, 32'h0);
    @(posedge CLK); #1;
    chk("ready_after_release", {31'b0, bus.INSTR_READY}, 32'h1);

    // Normal operation after reset
    exp_q.push_back(dec_ev(3'd2, 3'd1, 3'd4, 3'b001, 1'b0, 1'b0, 8'h01));
    exp_q.push_back(wr_ev(3'd4, 8'd3));
    issue(32'h02040201, 1'b0, 0);

    repeat (10) @(posedge CLK);
    #1 chk("queue_drained", 32'(exp_q.size()), 32'h0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
